// File: rtl/name_word_assembler.sv
// Collects a valid/ready stream of name words into a parallel name vector.
// One name assembles while the previously completed name waits at the output.
module name_word_assembler #(
    parameter int WORD_SIZE       = 32,
    parameter int MAX_NAME_LENGTH = 8,
    parameter int LEN_W           = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WORD_SIZE-1:0]                 in_word,
    input  logic                                 in_last,
    output logic                                 name_valid,
    input  logic                                 name_ready,
    output logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] name_out,
    output logic [LEN_W-1:0]                     name_len,
    output logic                                 name_trunc
);

    localparam int                NAME_W = MAX_NAME_LENGTH * WORD_SIZE;
    localparam logic [LEN_W-1:0]  MAX_L  = LEN_W'(MAX_NAME_LENGTH);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t              r_state;
    logic [NAME_W-1:0]   r_buf;
    logic [LEN_W-1:0]    r_idx;
    logic                r_trunc;
    logic [NAME_W-1:0]   r_name_out;
    logic [LEN_W-1:0]    r_name_len;
    logic                r_name_trunc;
    logic                r_name_valid;

    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_out_free;
    logic                w_room;
    logic [NAME_W-1:0]   w_nbuf;
    logic [LEN_W-1:0]    w_nlen;
    logic                w_ntrunc;

    assign in_ready   = (r_state == COLLECT) && rst_n;
    assign name_valid = r_name_valid;
    assign name_out   = r_name_out;
    assign name_len   = r_name_len;
    assign name_trunc = r_name_trunc;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_name_valid && name_ready;
    assign w_out_free = !r_name_valid || name_ready;
    assign w_room     = (r_idx < MAX_L);

    // Assembly state as it would be after accepting in_word this cycle.
    always_comb begin
        w_nbuf   = r_buf;
        w_nlen   = w_room ? r_idx + 1'b1 : r_idx;
        w_ntrunc = r_trunc || !w_room;
        for (int k = 0; k < MAX_NAME_LENGTH; k++) begin
            if (w_room && (r_idx == LEN_W'(k))) begin
                w_nbuf[k*WORD_SIZE +: WORD_SIZE] = in_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= COLLECT;
            r_buf        <= '0;
            r_idx        <= '0;
            r_trunc      <= 1'b0;
            r_name_out   <= '0;
            r_name_len   <= '0;
            r_name_trunc <= 1'b0;
            r_name_valid <= 1'b0;
        end else begin
            if (w_out_xfer) begin
                r_name_valid <= 1'b0;
            end
            case (r_state)
                COLLECT: begin
                    if (w_in_xfer) begin
                        if (in_last && w_out_free) begin
                            r_name_out   <= w_nbuf;
                            r_name_len   <= w_nlen;
                            r_name_trunc <= w_ntrunc;
                            r_name_valid <= 1'b1;
                            r_buf        <= '0;
                            r_idx        <= '0;
                            r_trunc      <= 1'b0;
                        end else begin
                            // A finished name that cannot move out parks in the assembly buffer.
                            r_buf   <= w_nbuf;
                            r_idx   <= w_nlen;
                            r_trunc <= w_ntrunc;
                            if (in_last) begin
                                r_state <= HOLD;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (w_out_xfer) begin
                        r_name_out   <= r_buf;
                        r_name_len   <= r_idx;
                        r_name_trunc <= r_trunc;
                        r_name_valid <= 1'b1;
                        r_buf        <= '0;
                        r_idx        <= '0;
                        r_trunc      <= 1'b0;
                        r_state      <= COLLECT;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_name_word_assembler.sv
// Bench for name_word_assembler: directed scenarios plus randomized names with
// random back-pressure, scored against a queue of expected name vectors.
module tb_name_word_assembler;

    localparam int W  = 32;
    localparam int M  = 8;
    localparam int LW = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_word;
    logic           in_last;
    logic           name_valid;
    logic           name_ready;
    logic [M*W-1:0] name_out;
    logic [LW-1:0]  name_len;
    logic           name_trunc;

    name_word_assembler #(.WORD_SIZE(W), .MAX_NAME_LENGTH(M), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_last(in_last),
        .name_valid(name_valid), .name_ready(name_ready), .name_out(name_out),
        .name_len(name_len), .name_trunc(name_trunc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [M*W-1:0] v;
        int             len;
        bit             tr;
    } name_t;

    name_t exp_q[$];
    int    n_checks = 0;
    int    n_err    = 0;
    int    n_xfer   = 0;
    bit    rnd_rdy  = 1'b0;

    task automatic check(input string tag, input logic [M*W-1:0] got, input logic [M*W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and output-stability monitor, sampled mid-cycle.
    logic [M*W-1:0] prev_out;
    logic [LW-1:0]  prev_len;
    logic           prev_tr;
    bit             prev_hold = 1'b0;

    always @(negedge clk) begin : monitor
        name_t e;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", name_valid, 1);
                check("hold_out", name_out, prev_out);
                check("hold_len", name_len, prev_len);
                check("hold_trunc", name_trunc, prev_tr);
            end
            if (name_valid && name_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    check("spurious_name", name_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("name_out", name_out, e.v);
                    check("name_len", name_len, e.len);
                    check("name_trunc", name_trunc, e.tr);
                end
            end
            prev_hold = name_valid && !name_ready;
            prev_out  = name_out;
            prev_len  = name_len;
            prev_tr   = name_trunc;
        end
    end

    task automatic send_word(input logic [W-1:0] w, input logic last, output int stalls);
        bit acc;
        stalls   = 0;
        in_valid = 1'b1;
        in_word  = w;
        in_last  = last;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (rnd_rdy) name_ready = 1'($urandom_range(0, 1));
            if (acc) break;
            stalls++;
            if (stalls > 200) begin
                check("word_timeout", in_ready, 1);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_name(input int n, input logic [W-1:0] base, input bit rnd_words, output int stalls);
        name_t        e;
        logic [W-1:0] ws[$];
        logic [W-1:0] w;
        int           s;
        e.v    = '0;
        e.len  = (n > M) ? M : n;
        e.tr   = (n > M);
        stalls = 0;
        for (int k = 0; k < n; k++) begin
            w = rnd_words ? $urandom : base + W'(k);
            ws.push_back(w);
            if (k < M) e.v[k*W +: W] = w;
        end
        exp_q.push_back(e);
        for (int k = 0; k < n; k++) begin
            send_word(ws[k], (k == n - 1), s);
            stalls += s;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        name_ready = 1'b1;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
        check("valid_drop", name_valid, 0);
    endtask

    initial begin
        int    s;
        int    x0;
        name_t e;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_word    = '0;
        in_last    = 1'b0;
        name_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", name_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_len", name_len, 0);
        check("rst_out", name_out, 0);
        check("rst_trunc", name_trunc, 0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", in_ready, 1);

        // 3-word name, latency and zero padding
        name_ready = 1'b1;
        send_name(3, 32'hA1, 1'b0, s);
        check("t1_latency", name_valid, 1);
        check("t1_in_ready", in_ready, 1);
        // full-length, then overlong names
        send_name(8, 32'h10, 1'b0, s);
        check("t2_stalls", s, 0);
        send_name(10, 32'h20, 1'b0, s);
        check("t3_stalls", s, 0);
        send_name(2, 32'h30, 1'b0, s);
        drain();

        // back-pressure: N1 held on output, N2 parked, third name stalls
        name_ready = 1'b0;
        send_name(2, 32'hB0, 1'b0, s);
        check("t4_n1_stalls", s, 0);
        send_name(3, 32'hB1, 1'b0, s);
        check("t4_n2_stalls", s, 0);
        check("t4_hold_ready", in_ready, 0);
        check("t4_n1_valid", name_valid, 1);
        e.v = '0; e.v[W-1:0] = 32'hC3; e.len = 1; e.tr = 1'b0;
        exp_q.push_back(e);
        in_valid = 1'b1; in_word = 32'hC3; in_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t4_stall_ready", in_ready, 0);
        name_ready = 1'b1;
        @(posedge clk);
        #1;
        name_ready = 1'b0;
        check("t4_n2_valid", name_valid, 1);
        check("t4_n2_word0", name_out[W-1:0], 32'hB1);
        check("t4_n2_len", name_len, 3);
        check("t4_ready_back", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        check("t4_n3_parked", in_ready, 0);
        drain();

        // reset in the middle of a name
        name_ready = 1'b1;
        send_word(32'hDD0, 1'b0, s);
        send_word(32'hDD1, 1'b0, s);
        rst_n = 1'b0;
        #1;
        check("t5_valid", name_valid, 0);
        check("t5_in_ready", in_ready, 0);
        check("t5_len", name_len, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_name(1, 32'hBB, 1'b0, s);
        check("t5_len_live", name_len, 1);
        check("t5_out_live", name_out, {{(M-1)*W{1'b0}}, 32'hBB});
        drain();

        // eight 1-word names back to back
        name_ready = 1'b1;
        x0 = n_xfer;
        s  = 0;
        for (int i = 0; i < 8; i++) begin
            int si;
            send_name(1, 32'h60 + W'(i), 1'b0, si);
            s += si;
        end
        check("t6_stalls", s, 0);
        @(posedge clk);
        #1;
        check("t6_names", n_xfer - x0, 8);
        drain();

        // randomized names with random back-pressure
        rnd_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send_name($urandom_range(1, 12), '0, 1'b1, s);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                name_ready = 1'($urandom_range(0, 1));
            end
        end
        rnd_rdy = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
